id_ctrl_stage: RTL and testbench
================================

ID_CTRL_STAGE -- requirements
Module: id_ctrl_stage

Interface
REQ-001 SHALL have parameter ALU_OP_W, default 4, width of alu_op.
REQ-002 SHALL have parameter MD_LATENCY, default 4, cycles the shared multiply/divide unit stays busy per issued M-op (range 2..15).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports in_valid input 1, in_ready output 1, inst input 32: fetch-side handshake and instruction.
REQ-006 SHALL have ports out_valid output 1, out_ready input 1: execute-side handshake.
REQ-007 SHALL have port flush  input  1  kill held instruction (branch/jump taken).
REQ-008 SHALL have registered outputs wd_sel 2, sext_op 3, alub_sel 1, alu_op ALU_OP_W, dram_we 1, mem_f3 3, rf_we 1, branch 3, jump 2, rs1_used 1, rs2_used 1, rd 5, rs1 5, rs2 5, is_load 1, md_op 1, illegal 1.

Function
REQ-009 SHALL decode RV32I R/I/LOAD/S/B/JAL/JALR/LUI/AUIPC into a one-entry output register; latency exactly 1 cycle from accepted input to out_valid.
REQ-010 SHALL accept input (in_valid & in_ready) only when output register empty or drained same cycle (out_ready), no hazard stall, and md counter zero.
REQ-011 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-012 SHALL decode full funct3 set: slt/sltu/slti/sltiu, all six branches (branch = {funct3[2:1] encoded, branch flag}), load/store width via mem_f3 = funct3.
REQ-013 SHALL distinguish LUI (wd_sel = sext) and AUIPC (wd_sel = ALU, operand A = pc via alub/op encoding in shared package).
REQ-014 SHALL force rf_we=0 when rd=0 or opcode is S/B.
REQ-015 SHALL set illegal=1, rf_we=0, dram_we=0, jump=0, branch flag=0 for any unrecognised opcode or funct3/funct7 combination; instruction still handshakes through.
REQ-016 SHALL detect load-use: held instruction is_load & rf_we & out_valid, and incoming rs1 (if rs1_used) or rs2 (if rs2_used) equals held rd -> in_ready=0 for that cycle; after held load drains, output a bubble (out_valid=0) for exactly one cycle, then accept.
REQ-017 SHALL on flush=1 clear out_valid next edge, drop the instruction being accepted that cycle, clear hazard bubble state; md counter is NOT cleared (unit still busy).
REQ-018 SHALL give flush priority over out_ready and in_valid in the same cycle.
REQ-019 SHALL, on issuing md_op=1 (accepted at out_ready), load md counter with MD_LATENCY-1 and decrement to 0; in_ready=0 only for incoming md_op instructions while counter nonzero; non-M instructions pass.

Reset
REQ-020 SHALL on rst_n=0 immediately set out_valid=0, all control outputs 0, illegal=0, md counter 0, bubble state 0; in_ready=1 on the first cycle after release.
REQ-021 SHALL discard any in-flight handshake when reset asserts mid-transfer.

Configuration
REQ-022 SHALL compile MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU decode (funct7=0000001) and md counter only when RV_M_EXT_EN is defined.
REQ-023 SHALL, without RV_M_EXT_EN, tie md_op=0, omit the counter, and flag funct7=0000001 R-type as illegal.

Structure
REQ-024 SHALL place opcode constants, IMM_* sext codes, wd_sel codes, ALU op codes (ADD..SLTU, M ops) and alub codes in the shared parameter package/include.
REQ-025 SHALL split pure combinational decode into sub-module id_decode_comb; id_ctrl_stage owns handshake, hazard, flush and md counter.

Verification
REQ-026 SHALL cover: reset then add x3,x1,x2 with out_ready=1 -> out_valid next cycle, alu_op=ADD, rf_we=1, rd=3.
REQ-027 SHALL cover: lw x5,0(x1) then add x6,x5,x2 -> in_ready=0 one cycle, one bubble cycle, add issued two cycles after lw.
REQ-028 SHALL cover: out_ready=0 for 3 cycles with sub held -> outputs unchanged, in_ready=0 throughout.
REQ-029 SHALL cover: flush=1 same cycle as in_valid=1 beq -> out_valid=0 next cycle, beq not issued.
REQ-030 SHALL cover: RV_M_EXT_EN, MD_LATENCY=4, mul then div back-to-back -> div held 3 cycles; without macro mul -> illegal=1, rf_we=0.
REQ-031 SHALL cover: inst=0x0000007F -> illegal=1, dram_we=0; addi x0,x0,1 -> rf_we=0.

Source files
------------

// File: rtl/id_ctrl_stage_pkg.sv
// id_ctrl_stage_pkg: shared encodings for the ID control stage and its decoder.
package id_ctrl_stage_pkg;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MD   = 7'b0000001;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } sext_e;

    typedef enum logic [1:0] {
        WD_ALU  = 2'd0,
        WD_DRAM = 2'd1,
        WD_PC4  = 2'd2,
        WD_SEXT = 2'd3
    } wd_e;

    typedef enum logic [1:0] {
        JMP_NONE = 2'd0,
        JMP_JAL  = 2'd1,
        JMP_JALR = 2'd2
    } jump_e;

    localparam logic ALUB_RS2 = 1'b0;
    localparam logic ALUB_IMM = 1'b1;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    // ADD with operand A taken from pc instead of rs1 (AUIPC)
    localparam logic [3:0] ALU_APC  = 4'd10;

    // M ops reuse funct3 as the op code and are qualified by md_op
    localparam logic [3:0] MD_MUL    = 4'd0;
    localparam logic [3:0] MD_MULH   = 4'd1;
    localparam logic [3:0] MD_MULHSU = 4'd2;
    localparam logic [3:0] MD_MULHU  = 4'd3;
    localparam logic [3:0] MD_DIV    = 4'd4;
    localparam logic [3:0] MD_DIVU   = 4'd5;
    localparam logic [3:0] MD_REM    = 4'd6;
    localparam logic [3:0] MD_REMU   = 4'd7;

    typedef struct packed {
        wd_e         wd_sel;
        sext_e       sext_op;
        logic        alub_sel;
        logic [3:0]  alu_op;
        logic        dram_we;
        logic [2:0]  mem_f3;
        logic        rf_we;
        logic [2:0]  branch;
        jump_e       jump;
        logic        rs1_used;
        logic        rs2_used;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        is_load;
        logic        md_op;
        logic        illegal;
    } ctrl_t;

    function automatic logic [3:0] alu_base(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/id_decode_comb.sv
// id_decode_comb: pure combinational RV32I decode into a ctrl_t bundle.
// RV_M_EXT_EN adds RV32M (funct7=0000001) decode; otherwise those encodings are illegal.
module id_decode_comb
    import id_ctrl_stage_pkg::*;
(
    input  logic [31:0] inst,
    output ctrl_t       ctrl
);
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    logic       legal;

    assign opc = inst[6:0];
    assign f3  = inst[14:12];
    assign f7  = inst[31:25];

    always_comb begin
        ctrl = '0;
        legal = 1'b1;
        case (opc)
            OP_R: begin
                ctrl.rs1_used = 1'b1;
                ctrl.rs2_used = 1'b1;
                ctrl.rf_we = 1'b1;
                ctrl.alu_op = alu_base(f3, f7[5]);
                legal = f7 == F7_BASE || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
`ifdef RV_M_EXT_EN
                if (f7 == F7_MD) begin
                    ctrl.md_op = 1'b1;
                    ctrl.alu_op = {1'b0, f3};
                    legal = 1'b1;
                end
`endif
            end
            OP_I: begin
                ctrl.rs1_used = 1'b1;
                ctrl.rf_we = 1'b1;
                ctrl.alub_sel = ALUB_IMM;
                ctrl.sext_op = IMM_I;
                ctrl.alu_op = alu_base(f3, f3 == 3'b101 && f7[5]);
                legal = f3 == 3'b001 ? f7 == F7_BASE :
                        f3 == 3'b101 ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1;
            end
            OP_LOAD: begin
                ctrl.rs1_used = 1'b1;
                ctrl.rf_we = 1'b1;
                ctrl.alub_sel = ALUB_IMM;
                ctrl.sext_op = IMM_I;
                ctrl.wd_sel = WD_DRAM;
                ctrl.is_load = 1'b1;
                ctrl.mem_f3 = f3;
                legal = !(f3 == 3'b011 || f3[2:1] == 2'b11);
            end
            OP_S: begin
                ctrl.rs1_used = 1'b1;
                ctrl.rs2_used = 1'b1;
                ctrl.alub_sel = ALUB_IMM;
                ctrl.sext_op = IMM_S;
                ctrl.dram_we = 1'b1;
                ctrl.mem_f3 = f3;
                legal = !f3[2] && f3 != 3'b011;
            end
            OP_B: begin
                // full funct3 is also carried on mem_f3 so eq/ne stays recoverable
                ctrl.rs1_used = 1'b1;
                ctrl.rs2_used = 1'b1;
                ctrl.sext_op = IMM_B;
                ctrl.alu_op = ALU_SUB;
                ctrl.branch = {f3[2:1], 1'b1};
                ctrl.mem_f3 = f3;
                legal = f3[2:1] != 2'b01;
            end
            OP_JAL: begin
                ctrl.rf_we = 1'b1;
                ctrl.sext_op = IMM_J;
                ctrl.wd_sel = WD_PC4;
                ctrl.jump = JMP_JAL;
            end
            OP_JALR: begin
                ctrl.rs1_used = 1'b1;
                ctrl.rf_we = 1'b1;
                ctrl.alub_sel = ALUB_IMM;
                ctrl.sext_op = IMM_I;
                ctrl.wd_sel = WD_PC4;
                ctrl.jump = JMP_JALR;
                legal = f3 == 3'b000;
            end
            OP_LUI: begin
                ctrl.rf_we = 1'b1;
                ctrl.alub_sel = ALUB_IMM;
                ctrl.sext_op = IMM_U;
                ctrl.wd_sel = WD_SEXT;
            end
            OP_AUIPC: begin
                ctrl.rf_we = 1'b1;
                ctrl.alub_sel = ALUB_IMM;
                ctrl.sext_op = IMM_U;
                ctrl.alu_op = ALU_APC;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) ctrl = '0;
        ctrl.illegal = !legal;
        ctrl.rd = inst[11:7];
        ctrl.rs1 = inst[19:15];
        ctrl.rs2 = inst[24:20];
        ctrl.rf_we = ctrl.rf_we & (inst[11:7] != 5'd0);
    end
endmodule

// File: rtl/id_ctrl_stage.sv
// id_ctrl_stage: one-entry ID output register with load-use, flush and M-unit busy interlocks.
// RV_M_EXT_EN enables RV32M decode and the multiply/divide busy counter.
module id_ctrl_stage
    import id_ctrl_stage_pkg::*;
#(
    parameter int ALU_OP_W   = 4,
    parameter int MD_LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         inst,
    output logic                out_valid,
    input  logic                out_ready,
    input  logic                flush,
    output logic [1:0]          wd_sel,
    output logic [2:0]          sext_op,
    output logic                alub_sel,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                dram_we,
    output logic [2:0]          mem_f3,
    output logic                rf_we,
    output logic [2:0]          branch,
    output logic [1:0]          jump,
    output logic                rs1_used,
    output logic                rs2_used,
    output logic [4:0]          rd,
    output logic [4:0]          rs1,
    output logic [4:0]          rs2,
    output logic                is_load,
    output logic                md_op,
    output logic                illegal
);
    ctrl_t d;
    ctrl_t q;
    logic  hazard;
    logic  md_stall;
    logic  accept;

    id_decode_comb u_decode (.inst(inst), .ctrl(d));

    // Stalling in the drain cycle leaves the register empty next cycle: that is the bubble.
    assign hazard = out_valid & q.is_load & q.rf_we &
                    ((d.rs1_used & (d.rs1 == q.rd)) | (d.rs2_used & (d.rs2 == q.rd)));
    assign in_ready = (!out_valid | out_ready) & !hazard & !md_stall;
    assign accept = in_valid & in_ready;

`ifdef RV_M_EXT_EN
    logic [3:0] md_cnt;
    logic       md_issue;

    assign md_issue = out_valid & out_ready & q.md_op & !flush;
    // A new M-op may enter once it would leave on or after the cycle the count hits zero.
    assign md_stall = d.md_op & ((out_valid & q.md_op) | (md_cnt > 4'd1));

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) md_cnt <= 4'd0;
        else if (md_issue) md_cnt <= 4'(MD_LATENCY - 1);
        else if (md_cnt != 4'd0) md_cnt <= md_cnt - 4'd1;
`else
    // md_op is tied low in this build, so this never stalls.
    assign md_stall = d.md_op & (MD_LATENCY > 1);
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_valid <= 1'b0;
            q <= '0;
        end else if (flush) out_valid <= 1'b0;
        else if (accept) begin
            out_valid <= 1'b1;
            q <= d;
        end else if (out_ready) out_valid <= 1'b0;

    assign wd_sel   = q.wd_sel;
    assign sext_op  = q.sext_op;
    assign alub_sel = q.alub_sel;
    assign alu_op   = ALU_OP_W'(q.alu_op);
    assign dram_we  = q.dram_we;
    assign mem_f3   = q.mem_f3;
    assign rf_we    = q.rf_we;
    assign branch   = q.branch;
    assign jump     = q.jump;
    assign rs1_used = q.rs1_used;
    assign rs2_used = q.rs2_used;
    assign rd       = q.rd;
    assign rs1      = q.rs1;
    assign rs2      = q.rs2;
    assign is_load  = q.is_load;
    assign md_op    = q.md_op;
    assign illegal  = q.illegal;
endmodule

// File: tb/tb_id_ctrl_stage.sv
// tb_id_ctrl_stage: directed self-checking bench for id_ctrl_stage.
// Define RV_M_EXT_EN for both bench and RTL to exercise the M-extension path.
module tb_id_ctrl_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] inst;
    logic        out_valid;
    logic        out_ready;
    logic        flush;
    logic [1:0]  wd_sel;
    logic [2:0]  sext_op;
    logic        alub_sel;
    logic [3:0]  alu_op;
    logic        dram_we;
    logic [2:0]  mem_f3;
    logic        rf_we;
    logic [2:0]  branch;
    logic [1:0]  jump;
    logic        rs1_used;
    logic        rs2_used;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        is_load;
    logic        md_op;
    logic        illegal;

    int checks = 0;
    int failures = 0;

    localparam logic [31:0] I_ADD3 = 32'h002081B3;
    localparam logic [31:0] I_LW5  = 32'h0000A283;
    localparam logic [31:0] I_ADD6 = 32'h00228333;
    localparam logic [31:0] I_SUB7 = 32'h402083B3;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_MUL  = 32'h022081B3;
    localparam logic [31:0] I_DIV  = 32'h0220C233;

    id_ctrl_stage #(.ALU_OP_W(4), .MD_LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush), .wd_sel(wd_sel),
        .sext_op(sext_op), .alub_sel(alub_sel), .alu_op(alu_op), .dram_we(dram_we),
        .mem_f3(mem_f3), .rf_we(rf_we), .branch(branch), .jump(jump), .rs1_used(rs1_used),
        .rs2_used(rs2_used), .rd(rd), .rs1(rs1), .rs2(rs2), .is_load(is_load),
        .md_op(md_op), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b1;
        inst = I_ADD3;
        out_ready = 1'b1;
        flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we: got %0b want 0", rf_we); end
        checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal: got %0b want 0", illegal); end
        checks++; if ({alu_op, rd, md_op} !== 10'd0) begin failures++; $display("FAIL reset_ctrl: got %0h want 0", {alu_op, rd, md_op}); end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        tick();
    endtask

    task automatic test_add;
        in_valid = 1'b1;
        inst = I_ADD3;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL add_in_ready: got %0b want 1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL add_out_valid: got %0b want 1", out_valid); end
        checks++; if (alu_op !== 4'd0) begin failures++; $display("FAIL add_alu_op: got %0d want 0", alu_op); end
        checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL add_rf_we: got %0b want 1", rf_we); end
        checks++; if ({rd, rs1, rs2} !== {5'd3, 5'd1, 5'd2}) begin failures++; $display("FAIL add_regs: got %0d/%0d/%0d want 3/1/2", rd, rs1, rs2); end
        checks++; if ({rs1_used, rs2_used} !== 2'b11) begin failures++; $display("FAIL add_used: got %0b want 11", {rs1_used, rs2_used}); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL add_drain: got %0b want 0", out_valid); end
    endtask

    task automatic test_load_use;
        in_valid = 1'b1;
        inst = I_LW5;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_lw_ready: got %0b want 1", in_ready); end
        tick();
        checks++; if ({out_valid, is_load, rd} !== {1'b1, 1'b1, 5'd5}) begin failures++; $display("FAIL lu_lw_out: got %0h want %0h", {out_valid, is_load, rd}, {1'b1, 1'b1, 5'd5}); end
        inst = I_ADD6;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL lu_stall: got %0b want 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL lu_bubble: got %0b want 0", out_valid); end
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL lu_resume: got %0b want 1", in_ready); end
        tick();
        checks++; if ({out_valid, is_load, rd} !== {1'b1, 1'b0, 5'd6}) begin failures++; $display("FAIL lu_add_out: got %0h want %0h", {out_valid, is_load, rd}, {1'b1, 1'b0, 5'd6}); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall;
        in_valid = 1'b1;
        inst = I_SUB7;
        out_ready = 1'b0;
        tick();
        checks++; if ({out_valid, alu_op, rd} !== {1'b1, 4'd1, 5'd7}) begin failures++; $display("FAIL stall_sub: got %0h want %0h", {out_valid, alu_op, rd}, {1'b1, 4'd1, 5'd7}); end
        inst = I_ADD3;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready[%0d]: got %0b want 0", i, in_ready); end
            tick();
            checks++; if ({out_valid, alu_op, rd, rs1, rs2} !== {1'b1, 4'd1, 5'd7, 5'd1, 5'd2}) begin failures++; $display("FAIL stall_hold[%0d]: got %0h want %0h", i, {out_valid, alu_op, rd, rs1, rs2}, {1'b1, 4'd1, 5'd7, 5'd1, 5'd2}); end
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stall_release: got %0b want 1", in_ready); end
        tick();
        checks++; if ({out_valid, alu_op, rd} !== {1'b1, 4'd0, 5'd3}) begin failures++; $display("FAIL stall_next: got %0h want %0h", {out_valid, alu_op, rd}, {1'b1, 4'd0, 5'd3}); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush;
        in_valid = 1'b1;
        inst = I_ADD3;
        out_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL flush_setup: got %0b want 1", out_valid); end
        inst = I_BEQ;
        flush = 1'b1;
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_kill: got %0b want 0", out_valid); end
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        checks++; if ({out_valid, branch} !== 4'b0000) begin failures++; $display("FAIL flush_beq_dropped: got %0h want 0", {out_valid, branch}); end
    endtask

    task automatic test_decode;
        logic [31:0] tab_inst [11];
        logic [22:0] tab_exp [11];
        logic [22:0] got;
        tab_inst = '{32'h0000007F, 32'h00100013, 32'h12345537, 32'h00001597, 32'h0020B633, 32'h0020E463,
                     32'h0020A223, 32'h010000EF, 32'h40109093, 32'h0000A283, 32'h000100E7};
        tab_exp = '{
            {2'd0, 3'd0, 1'b0, 4'd0,  1'b0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1},
            {2'd0, 3'd1, 1'b1, 4'd0,  1'b0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0},
            {2'd3, 3'd4, 1'b1, 4'd0,  1'b0, 3'd0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0},
            {2'd0, 3'd4, 1'b1, 4'd10, 1'b0, 3'd0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0},
            {2'd0, 3'd0, 1'b0, 4'd9,  1'b0, 3'd0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0},
            {2'd0, 3'd3, 1'b0, 4'd1,  1'b0, 3'd6, 1'b0, 3'd7, 2'd0, 1'b0, 1'b0, 1'b0},
            {2'd0, 3'd2, 1'b1, 4'd0,  1'b1, 3'd2, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0},
            {2'd2, 3'd5, 1'b0, 4'd0,  1'b0, 3'd0, 1'b1, 3'd0, 2'd1, 1'b0, 1'b0, 1'b0},
            {2'd0, 3'd0, 1'b0, 4'd0,  1'b0, 3'd0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1},
            {2'd1, 3'd1, 1'b1, 4'd0,  1'b0, 3'd2, 1'b1, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0},
            {2'd2, 3'd1, 1'b1, 4'd0,  1'b0, 3'd0, 1'b1, 3'd0, 2'd2, 1'b0, 1'b0, 1'b0}};
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            inst = tab_inst[i];
            #1;
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL dec_ready[%0d]: got %0b want 1", i, in_ready); end
            tick();
            got = {wd_sel, sext_op, alub_sel, alu_op, dram_we, mem_f3, rf_we, branch, jump, is_load, md_op, illegal};
            checks++; if ({out_valid, got} !== {1'b1, tab_exp[i]}) begin failures++; $display("FAIL dec[%0d] inst=%08h: got %0h want %0h", i, tab_inst[i], {out_valid, got}, {1'b1, tab_exp[i]}); end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_md;
        in_valid = 1'b1;
        out_ready = 1'b1;
        inst = I_MUL;
        tick();
`ifdef RV_M_EXT_EN
        checks++; if ({out_valid, md_op, alu_op, rf_we} !== {1'b1, 1'b1, 4'd0, 1'b1}) begin failures++; $display("FAIL md_mul: got %0h want %0h", {out_valid, md_op, alu_op, rf_we}, {1'b1, 1'b1, 4'd0, 1'b1}); end
        inst = I_DIV;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL md_div_held[%0d]: got %0b want 0", i, in_ready); end
            tick();
        end
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL md_div_accept: got %0b want 1", in_ready); end
        tick();
        checks++; if ({out_valid, md_op, alu_op, rd} !== {1'b1, 1'b1, 4'd4, 5'd4}) begin failures++; $display("FAIL md_div_out: got %0h want %0h", {out_valid, md_op, alu_op, rd}, {1'b1, 1'b1, 4'd4, 5'd4}); end
`else
        checks++; if ({out_valid, illegal, rf_we, md_op} !== 4'b1100) begin failures++; $display("FAIL md_mul_illegal: got %0b want 1100", {out_valid, illegal, rf_we, md_op}); end
`endif
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        in_valid = 1'b1;
        inst = I_ADD3;
        out_ready = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rmid_setup: got %0b want 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if ({out_valid, rf_we, rd} !== 7'd0) begin failures++; $display("FAIL rmid_async: got %0h want 0", {out_valid, rf_we, rd}); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready: got %0b want 1", in_ready); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_discard: got %0b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_use();
        test_stall();
        test_flush();
        test_decode();
        test_md();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1);
    end
endmodule
